// File: rtl/quad_bit_deserializer_if.sv
// Bus bundle for quad_bit_deserializer: the serial bit input side and the
// buffered 4-bit word output side, including the abort indication.
interface quad_bit_deserializer_if;
    logic sin_valid;
    logic sin_data;
    logic sin_start;
    logic sin_ready;
    logic out_valid;
    logic out_ready;
    logic out_a;
    logic out_b;
    logic out_c;
    logic out_d;
    logic out_all;
    logic out_any;
    logic frame_err;

    // Environment side: produces serial bits and consumes words
    modport master (
        output sin_valid, sin_data, sin_start, out_ready,
        input  sin_ready, out_valid, out_a, out_b, out_c, out_d,
               out_all, out_any, frame_err
    );

    // Deserializer side
    modport slave (
        input  sin_valid, sin_data, sin_start, out_ready,
        output sin_ready, out_valid, out_a, out_b, out_c, out_d,
               out_all, out_any, frame_err
    );
endinterface

// File: rtl/quad_bit_deserializer.sv
// Collects a framed 1-bit serial stream into 4-bit words and buffers up to
// two finished words behind a valid/ready handshake. Each word is presented
// as four discrete bits plus their AND/OR reductions.
module quad_bit_deserializer #(
    parameter int LSB_FIRST = 0,
    parameter int GAP_MAX   = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    quad_bit_deserializer_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Last gap count value before the idle cycle that aborts the frame
    localparam logic [7:0] GAP_LAST = 8'(GAP_MAX - 1);

    state_t      state_q;
    logic [1:0]  count_q;
    logic [3:0]  shift_q;
    logic [7:0]  gap_q;
    logic        frame_err_q;

    logic [3:0]  mem_q [2];
    logic        wrPtr_q;
    logic        rdPtr_q;
    logic [1:0]  occ_q;
    logic [1:0]  occ_d;

    logic        accept;
    logic        pushEn;
    logic        popEn;
    logic [3:0]  word_d;
    logic [3:0]  headWord;

    // Word bit index for serial position pos; word bit 0 is out_a, 3 is out_d
    function automatic logic [1:0] mapIdx(input logic [1:0] pos);
        if (LSB_FIRST != 0) begin
            return 2'd3 - pos;
        end
        return pos;
    endfunction

    // A word holding only the given serial bit at its mapped position
    function automatic logic [3:0] placeBit(input logic [1:0] pos, input logic bitVal);
        logic [3:0] w;
        w = '0;
        w[mapIdx(pos)] = bitVal;
        return w;
    endfunction

    assign bus.sin_ready = (occ_q < 2'd2);
    assign accept        = bus.sin_valid & bus.sin_ready;
    assign pushEn        = accept && (state_q == SHIFT) && !bus.sin_start && (count_q == 2'd3);
    assign popEn         = bus.out_valid & bus.out_ready;

    // Completed word and next FIFO occupancy
    always_comb begin
        word_d = shift_q | placeBit(2'd3, bus.sin_data);
        occ_d  = occ_q;
        if (pushEn && !popEn) begin
            occ_d = occ_q + 2'd1;
        end else if (!pushEn && popEn) begin
            occ_d = occ_q - 2'd1;
        end
    end

    // Frame assembly FSM: bit collection, restart and idle-gap abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 2'd0;
            shift_q     <= 4'd0;
            gap_q       <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    gap_q <= 8'd0;
                    if (accept && bus.sin_start) begin
                        shift_q <= placeBit(2'd0, bus.sin_data);
                        count_q <= 2'd1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        gap_q <= 8'd0;
                        if (bus.sin_start) begin
                            shift_q     <= placeBit(2'd0, bus.sin_data);
                            count_q     <= 2'd1;
                            frame_err_q <= 1'b1;
                        end else if (count_q == 2'd3) begin
                            shift_q <= 4'd0;
                            count_q <= 2'd0;
                            state_q <= IDLE;
                        end else begin
                            shift_q <= shift_q | placeBit(count_q, bus.sin_data);
                            count_q <= count_q + 2'd1;
                        end
                    end else if (bus.sin_ready) begin
                        if (gap_q == GAP_LAST) begin
                            shift_q     <= 4'd0;
                            count_q     <= 2'd0;
                            gap_q       <= 8'd0;
                            frame_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            gap_q <= gap_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Two-entry word FIFO; a push and pop at occupancy 1 hands over the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= 4'd0;
            mem_q[1] <= 4'd0;
            wrPtr_q  <= 1'b0;
            rdPtr_q  <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (pushEn) begin
                mem_q[wrPtr_q] <= word_d;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (popEn) begin
                rdPtr_q <= ~rdPtr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign bus.out_valid = (occ_q != 2'd0);
    assign headWord      = bus.out_valid ? mem_q[rdPtr_q] : 4'd0;
    assign bus.out_a     = headWord[0];
    assign bus.out_b     = headWord[1];
    assign bus.out_c     = headWord[2];
    assign bus.out_d     = headWord[3];
    assign bus.out_all   = &headWord;
    assign bus.out_any   = |headWord;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_quad_bit_deserializer.sv
// Directed bench for quad_bit_deserializer. Two instances share one stimulus
// stream: dut0 maps the first serial bit to out_a, dut1 maps it to out_d.
module tb_quad_bit_deserializer;

    logic clk;
    logic rst_n;
    logic rdy;
    int   checks;
    int   failures;

    quad_bit_deserializer_if bus0 ();
    quad_bit_deserializer_if bus1 ();

    quad_bit_deserializer #(.LSB_FIRST(0), .GAP_MAX(15)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    quad_bit_deserializer #(.LSB_FIRST(1), .GAP_MAX(15)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {valid, a, b, c, d, all, any} of each instance
    function automatic logic [6:0] word0();
        return {bus0.out_valid, bus0.out_a, bus0.out_b, bus0.out_c, bus0.out_d,
                bus0.out_all, bus0.out_any};
    endfunction

    function automatic logic [6:0] word1();
        return {bus1.out_valid, bus1.out_a, bus1.out_b, bus1.out_c, bus1.out_d,
                bus1.out_all, bus1.out_any};
    endfunction

    task automatic applyStimulus(input logic v, input logic d, input logic s, input logic r);
        bus0.sin_valid = v;  bus1.sin_valid = v;
        bus0.sin_data  = d;  bus1.sin_data  = d;
        bus0.sin_start = s;  bus1.sin_start = s;
        bus0.out_ready = r;  bus1.out_ready = r;
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic d, input logic s);
        applyStimulus(1'b1, d, s, rdy);
        tick();
    endtask

    task automatic quiet();
        applyStimulus(1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic sendFrame(input logic b0, input logic b1, input logic b2, input logic b3);
        sendBit(b0, 1'b1);
        sendBit(b1, 1'b0);
        sendBit(b2, 1'b0);
        sendBit(b3, 1'b0);
        quiet();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rdy      = 1'b1;
        rst_n    = 1'b0;
        quiet();
        #2;
        $display("[TB] reset state");
        checkOutput("reset_word0", word0(), 7'b0000000);
        checkOutput("reset_word1", word1(), 7'b0000000);
        checkOutput("reset_err_rdy", {6'd0, bus0.frame_err}, 7'd0);
        checkOutput("reset_sin_ready", {6'd0, bus0.sin_ready}, 7'd1);
        tick();
        rst_n = 1'b1;

        $display("[TB] basic frame 1,0,1,1");
        sendFrame(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("basic_word0", word0(), 7'b1101101);
        checkOutput("basic_err", {6'd0, bus0.frame_err}, 7'd0);
        tick();
        checkOutput("basic_popped", word0(), 7'b0000000);

        $display("[TB] msb-first mapping");
        sendFrame(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("ones_word1", word1(), 7'b1111111);
        sendFrame(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("zeros_word1", word1(), 7'b1000000);
        tick();
        sendFrame(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("first_to_d_word1", word1(), 7'b1000101);
        checkOutput("first_to_a_word0", word0(), 7'b1100001);
        tick();

        $display("[TB] backpressure with three frames");
        rdy = 1'b0;
        quiet();
        sendFrame(1'b1, 1'b0, 1'b0, 1'b0);
        sendFrame(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_full_ready", {6'd0, bus0.sin_ready}, 7'd0);
        checkOutput("bp_head1", word0(), 7'b1100001);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("bp_stall_ready", {6'd0, bus0.sin_ready}, 7'd0);
        checkOutput("bp_stall_stable", word0(), 7'b1100001);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("bp_head2", word0(), 7'b1010001);
        checkOutput("bp_ready_back", {6'd0, bus0.sin_ready}, 7'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b1, 1'b0);
        quiet();
        checkOutput("bp_refull_ready", {6'd0, bus0.sin_ready}, 7'd0);
        checkOutput("bp_head2_held", word0(), 7'b1010001);
        rdy = 1'b1;
        quiet();
        tick();
        checkOutput("bp_head3", word0(), 7'b1001101);
        tick();
        checkOutput("bp_drained", word0(), 7'b0000000);

        $display("[TB] idle gap abort");
        sendBit(1'b1, 1'b1);
        sendBit(1'b0, 1'b0);
        quiet();
        repeat (14) tick();
        checkOutput("gap_before_limit", {6'd0, bus0.frame_err}, 7'd0);
        tick();
        checkOutput("gap_err_pulse", {6'd0, bus0.frame_err}, 7'd1);
        tick();
        checkOutput("gap_err_cleared", {6'd0, bus0.frame_err}, 7'd0);
        checkOutput("gap_no_word", word0(), 7'b0000000);
        sendBit(1'b1, 1'b0);
        quiet();
        tick();
        checkOutput("gap_stray_discarded", word0(), 7'b0000000);
        sendFrame(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("gap_next_word0", word0(), 7'b1011001);
        tick();

        $display("[TB] restart mid-frame");
        sendBit(1'b1, 1'b1);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b1);
        checkOutput("restart_err_pulse", {6'd0, bus0.frame_err}, 7'd1);
        sendBit(1'b1, 1'b0);
        checkOutput("restart_err_cleared", {6'd0, bus0.frame_err}, 7'd0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        quiet();
        checkOutput("restart_word0", word0(), 7'b1010101);
        checkOutput("restart_word1", word1(), 7'b1101001);
        tick();

        $display("[TB] asynchronous reset with buffered data");
        rdy = 1'b0;
        quiet();
        sendFrame(1'b1, 1'b1, 1'b0, 1'b0);
        sendBit(1'b1, 1'b1);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        quiet();
        checkOutput("arst_before", word0(), 7'b1110001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid_drop", word0(), 7'b0000000);
        checkOutput("arst_sin_ready", {6'd0, bus0.sin_ready}, 7'd1);
        tick();
        rst_n = 1'b1;
        rdy   = 1'b1;
        quiet();
        tick();
        checkOutput("arst_still_empty", word0(), 7'b0000000);
        sendFrame(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("arst_next_word0", word0(), 7'b1000101);
        checkOutput("arst_next_word1", word1(), 7'b1100001);
        checkOutput("arst_no_err", {6'd0, bus0.frame_err}, 7'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_bit_deserializer.md
Name: quad_bit_deserializer

Overview:
- Receive-side counterpart to the 4-input reduction stage: collects a framed 1-bit serial stream into 4-bit words.
- Presents each word as four discrete bits out_a..out_d, plus precomputed AND/OR reductions.
- Output side buffers up to two completed words behind a valid/ready handshake.
- Sits between a serial link front-end and any block consuming four parallel single-bit inputs.

Parameters:
- LSB_FIRST, 0: 0 means the first serial bit lands on out_a; 1 means the first serial bit lands on out_d.
- GAP_MAX, 15: maximum consecutive idle cycles allowed between bits of one frame before the frame is aborted. Range 1..255.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- sin_valid, in, 1: serial bit present this cycle.
- sin_data, in, 1: serial bit value.
- sin_start, in, 1: qualifies sin_valid; marks bit 0 of a frame.
- sin_ready, out, 1: deserializer accepts a bit this cycle.
- out_valid, out, 1: head word valid.
- out_ready, in, 1: consumer accepts the head word.
- out_a / out_b / out_c / out_d, out, 1 each: head word bits.
- out_all, out, 1: out_a & out_b & out_c & out_d of the head word.
- out_any, out, 1: out_a | out_b | out_c | out_d of the head word.
- frame_err, out, 1: one-cycle pulse on an aborted or restarted frame.

Behaviour:
- Reset (async assert, sync-safe release):
  - FSM goes to IDLE; bit count 0; gap counter 0; FIFO empty.
  - out_valid=0, out_a..out_d=0, out_all=0, out_any=0, frame_err=0, sin_ready=1.
- Bit acceptance: a bit is accepted when sin_valid & sin_ready.
- sin_ready = (FIFO occupancy < 2). This is a registered occupancy compare; a same-cycle pop does not raise it.
- FSM state IDLE:
  - An accepted bit with sin_start=1 stores bit0, sets count=1, moves to SHIFT.
  - An accepted bit with sin_start=0 is discarded silently.
- FSM state SHIFT:
  - Accepted bit with sin_start=0: stored at position count, count increments.
  - When the 4th bit is accepted, the word is pushed to the FIFO in that same cycle and the FSM returns to IDLE.
  - Accepted bit with sin_start=1: the partial frame is dropped, frame_err pulses next cycle, and this bit becomes bit0 of a new frame (count=1, stay in SHIFT).
  - Each cycle without an accepted bit increments the gap counter; any accepted bit clears it.
  - If the gap counter reaches GAP_MAX: partial frame dropped, frame_err pulses, FSM returns to IDLE.
  - The gap counter does not increment while sin_ready=0 (backpressure is not a gap).
- Bit mapping:
  - LSB_FIRST=0: serial order is a, b, c, d.
  - LSB_FIRST=1: serial order is d, c, b, a.
- Word latency: out_valid rises on the clock edge following acceptance of the 4th bit when the FIFO was empty, i.e. 1 cycle after the last bit.
- FIFO:
  - Two entries, first-in first-out; head drives out_*.
  - out_all and out_any are computed from stored head bits, never from in-flight bits.
  - Pop occurs on out_valid & out_ready.
  - Simultaneous push and pop with occupancy 1 leaves occupancy 1 and the new word at the head next cycle.
  - Push cannot occur at occupancy 2, because sin_ready=0 blocks it.
- Output stability: while out_valid=1 and out_ready=0, out_a..out_d, out_all and out_any hold stable.
- Reset mid-frame or mid-handshake discards all partial and buffered data immediately.

Test Plan:
- Reset, then sin_start=1 with bits 1,0,1,1 (LSB_FIRST=0) on consecutive cycles, out_ready=1 -> one cycle after the 4th bit: out_valid=1, a=1, b=0, c=1, d=1, out_all=0, out_any=1; frame_err stays 0.
- LSB_FIRST=1, bits 1,1,1,1 then bits 0,0,0,0 -> word1 has all bits 1 with out_all=1; word2 has all bits 0 with out_any=0.
- out_ready=0, three frames sent back-to-back -> two words buffered; sin_ready=0 after the second word; third frame stalls at bit 0. Raise out_ready -> words pop in order and the third frame completes.
- Two bits accepted, then 15 idle cycles (GAP_MAX=15) -> frame_err pulses once, FSM returns to IDLE, no word is pushed. A following full frame decodes correctly.
- sin_start reasserted after 2 bits, then 3 more bits -> frame_err pulses once; the word equals the restart bit plus the 3 new bits.
- rst_n pulled low asynchronously with 1 word buffered and 3 bits of the next frame collected -> out_valid drops without waiting for clk. After release, the next frame is decoded from a clean state.
